regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width; depth is 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have ports addr1, addr2  input  ADDR_WIDTH  read port indices.
REQ-006 SHALL have ports data1, data2  output  DATA_WIDTH  read port data.
REQ-007 SHALL have ports write_enable  input  1, write_reg_addr  input  ADDR_WIDTH, reg_write_data  input  DATA_WIDTH  writeback port.
REQ-008 SHALL have ports issue_valid  input  1, issue_addr  input  ADDR_WIDTH  marks destination of a newly issued instruction as pending.
REQ-009 SHALL have port flush  input  1  clears all pending marks; register contents are kept.
REQ-010 SHALL have ports busy1, busy2  output  1  pending status of addr1 and addr2.
REQ-011 SHALL have port pending_count  output  ADDR_WIDTH  number of registers currently marked pending.

Function
REQ-012 Reads SHALL be combinational: data1/data2 reflect the register array contents and busy1/busy2 reflect the busy vector in the same cycle as the address.
REQ-013 Register 0 SHALL always read 0, SHALL never be written, and SHALL never be busy; any write, issue or read addressed to 0 is treated accordingly.
REQ-014 On posedge clk with write_enable=1 and write_reg_addr!=0, reg_write_data SHALL be stored and the busy bit of write_reg_addr SHALL be cleared.
REQ-015 On posedge clk with issue_valid=1, issue_addr!=0 and flush=0, the busy bit of issue_addr SHALL be set.
REQ-016 If issue and writeback target the same address in the same cycle, the data SHALL be written and the busy bit SHALL end set (issue wins).
REQ-017 A write to a non-busy register SHALL store data normally and leave the busy vector unchanged.
REQ-018 An issue to an already-busy register SHALL leave it busy; no per-register counting SHALL occur.
REQ-019 flush=1 SHALL clear every busy bit at the next edge; a same-cycle issue SHALL be ignored; a same-cycle write SHALL still store its data.
REQ-020 pending_count SHALL be registered and equal the population count of the busy vector after each edge; the maximum is 2**ADDR_WIDTH-1.
REQ-021 A read of a register in the cycle it is written SHALL return the old value unless REGFILE_BYPASS_EN is defined.

Reset
REQ-022 With reset=1 at posedge clk, all registers SHALL become 0, all busy bits 0 and pending_count 0; write, issue and flush inputs SHALL be ignored in that cycle.
REQ-023 After reset, data1/data2 SHALL read 0 and busy1/busy2 SHALL be 0 for all addresses.
REQ-024 Reset asserted mid-operation SHALL discard all pending marks and contents with no partial update.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-026 With REGFILE_BYPASS_EN defined, if write_enable=1 and write_reg_addr!=0 matches addr1 or addr2, the read SHALL return reg_write_data combinationally and the matching busy output SHALL be 0, unless issue_valid=1 (with flush=0) targets the same address.
REQ-027 Without REGFILE_BYPASS_EN, reads SHALL return only stored contents and busy outputs SHALL reflect only the registered busy vector.

Verification
REQ-028 Reset; read all 32 addresses -> every data1/data2 is 0, every busy is 0 and pending_count is 0.
REQ-029 Write x0=0xFFFFFFFF, then issue x0 -> data1(addr1=0)=0, busy1=0 and pending_count=0.
REQ-030 Issue x5 and x7, then write x5=0x12345678 -> after the write cycle busy(x5)=0, busy(x7)=1, pending_count=1 and data(x5)=0x12345678.
REQ-031 Issue x9 and write x9=0xA5A5A5A5 in the same cycle -> data(x9)=0xA5A5A5A5, busy(x9)=1 and pending_count increments by 1.
REQ-032 Issue x1..x4, then assert flush together with issue x6 and write x2=0x55 -> pending_count=0, all busy are 0 and data(x2)=0x55.
REQ-033 Write x3=0xDEAD with addr1=3 in the same cycle -> with REGFILE_BYPASS_EN, data1=0xDEAD in that cycle; without it, data1 shows the old value and 0xDEAD the next cycle.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Bundle of the register file / scoreboard signals: two combinational read
// ports, one writeback port, one issue port, the flush strobe and the
// busy/pending-count status outputs.
//   master : the pipeline side (drives addresses, writebacks, issues, flush)
//   slave  : the register file side (returns read data and busy status)
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] addr1;
    logic [ADDR_WIDTH-1:0] addr2;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_reg_addr;
    logic [DATA_WIDTH-1:0] reg_write_data;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  flush;
    logic                  busy1;
    logic                  busy2;
    logic [ADDR_WIDTH-1:0] pending_count;

    modport master (
        output addr1, addr2, write_enable, write_reg_addr, reg_write_data,
               issue_valid, issue_addr, flush,
        input  data1, data2, busy1, busy2, pending_count
    );

    modport slave (
        input  addr1, addr2, write_enable, write_reg_addr, reg_write_data,
               issue_valid, issue_addr, flush,
        output data1, data2, busy1, busy2, pending_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with an attached busy scoreboard.
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous active-high reset (clears contents, busy bits, count)
//   bus   : regfile_scoreboard_if.slave
//             addr1/addr2 -> data1/data2, busy1/busy2 (combinational reads)
//             write_enable/write_reg_addr/reg_write_data (writeback, clears busy)
//             issue_valid/issue_addr (marks destination pending)
//             flush (clears all pending marks, keeps contents)
//             pending_count (registered population count of busy bits)
// Register 0 reads as zero and is never written or marked busy.
// Optional macro REGFILE_BYPASS_EN: forwards a same-cycle writeback to the
// read ports (data and busy). Without it, reads show stored state only.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic               clk,
    input logic               reset,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]      busy_reg;
    logic [DEPTH-1:0]      busy_next;
    logic [ADDR_WIDTH-1:0] pending_count_reg;
    logic [ADDR_WIDTH-1:0] pending_count_next;

    // Writes and issues aimed at register 0 are dropped here so the rest of
    // the logic never needs to special-case index 0 on the update side.
    logic wr_hit;
    logic iss_hit;
    assign wr_hit  = bus.write_enable && (bus.write_reg_addr != '0);
    assign iss_hit = bus.issue_valid && (bus.issue_addr != '0) && !bus.flush;

    // Per-register busy update: flush beats everything, issue beats a
    // same-cycle writeback so a re-issued destination stays pending.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign busy_next[gi] =
                    bus.flush                                                ? 1'b0 :
                    (iss_hit && (bus.issue_addr == ADDR_WIDTH'(gi)))         ? 1'b1 :
                    (wr_hit  && (bus.write_reg_addr == ADDR_WIDTH'(gi)))     ? 1'b0 :
                                                                               busy_reg[gi];
            end
        end
    endgenerate

    // Bit 0 is never set, so the count tops out at DEPTH-1 and fits in
    // ADDR_WIDTH bits.
    always_comb begin
        pending_count_next = '0;
        for (int i = 1; i < DEPTH; i++) begin
            pending_count_next = pending_count_next + ADDR_WIDTH'(busy_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg          <= '0;
            pending_count_reg <= '0;
        end else begin
            if (wr_hit) begin
                regs_reg[bus.write_reg_addr] <= bus.reg_write_data;
            end
            busy_reg          <= busy_next;
            pending_count_reg <= pending_count_next;
        end
    end

    assign bus.pending_count = pending_count_reg;

    // Two identical read ports.
    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic                  rd_busy [2];

    assign rd_addr[0] = bus.addr1;
    assign rd_addr[1] = bus.addr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            logic [DATA_WIDTH-1:0] stored;
            assign stored = (rd_addr[gi] == '0) ? '0 : regs_reg[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
            logic fwd_hit;
            logic iss_same;
            assign fwd_hit  = wr_hit && (bus.write_reg_addr == rd_addr[gi]);
            assign iss_same = iss_hit && (bus.issue_addr == rd_addr[gi]);
            assign rd_data[gi] = fwd_hit ? bus.reg_write_data : stored;
            // A forwarded result is no longer pending, unless the same
            // register is being re-issued in this cycle.
            assign rd_busy[gi] = (fwd_hit && !iss_same) ? 1'b0 : busy_reg[rd_addr[gi]];
`else
            assign rd_data[gi] = stored;
            assign rd_busy[gi] = busy_reg[rd_addr[gi]];
`endif
        end
    endgenerate

    assign bus.data1 = rd_data[0];
    assign bus.data2 = rd_data[1];
    assign bus.busy1 = rd_busy[0];
    assign bus.busy2 = rd_busy[1];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against an
// array-based model of the register file and its busy set.
module tb_regfile_scoreboard;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk;
    logic reset;

    regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] model_regs [DEPTH];
    bit          model_busy [DEPTH];
    bit          model_valid = 1'b0;

    function automatic int model_pending();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(model_busy[i]);
        return n;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        logic [31:0] v;
        v = model_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (bus.write_enable && bus.write_reg_addr != 0 && bus.write_reg_addr == a)
            v = bus.reg_write_data;
`endif
        return v;
    endfunction

    function automatic logic model_busy_out(input logic [AW-1:0] a);
        logic b;
        b = model_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (bus.write_enable && bus.write_reg_addr != 0 && bus.write_reg_addr == a &&
            !(bus.issue_valid && !bus.flush && bus.issue_addr == a))
            b = 1'b0;
`endif
        return b;
    endfunction

    // State update at each edge, following the rules directly.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                model_regs[i] = '0;
                model_busy[i] = 1'b0;
            end
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (bus.write_enable && bus.write_reg_addr != 0)
                model_regs[bus.write_reg_addr] = bus.reg_write_data;
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) model_busy[i] = 1'b0;
            end else begin
                if (bus.write_enable && bus.write_reg_addr != 0)
                    model_busy[bus.write_reg_addr] = 1'b0;
                if (bus.issue_valid && bus.issue_addr != 0)
                    model_busy[bus.issue_addr] = 1'b1;
            end
        end
    end

    // Compare process: inputs change at negedge, outputs sampled 2ns later.
    always @(negedge clk) begin
        #2;
        if (model_valid) begin
            check("cmp_data1", bus.data1, model_read(bus.addr1));
            check("cmp_data2", bus.data2, model_read(bus.addr2));
            check("cmp_busy1", 32'(bus.busy1), 32'(model_busy_out(bus.addr1)));
            check("cmp_busy2", 32'(bus.busy2), 32'(model_busy_out(bus.addr2)));
            check("cmp_pending", 32'(bus.pending_count), 32'(model_pending()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit rst, input bit we, input int wa, input logic [31:0] wd,
                         input bit iv, input int ia, input bit fl, input int a1, input int a2);
        @(negedge clk);
        reset               = rst;
        bus.write_enable    = we;
        bus.write_reg_addr  = AW'(wa);
        bus.reg_write_data  = wd;
        bus.issue_valid     = iv;
        bus.issue_addr      = AW'(ia);
        bus.flush           = fl;
        bus.addr1           = AW'(a1);
        bus.addr2           = AW'(a2);
    endtask

    task automatic idle(input int a1, input int a2);
        drive(0, 0, 0, 32'h0, 0, 0, 0, a1, a2);
    endtask

    initial begin
        reset = 1'b1;
        bus.write_enable = 0; bus.write_reg_addr = '0; bus.reg_write_data = '0;
        bus.issue_valid = 0; bus.issue_addr = '0; bus.flush = 0;
        bus.addr1 = '0; bus.addr2 = '0;

        // Reset, with garbage on write/issue inputs that must be ignored.
        drive(1, 1, 4, 32'hCAFEF00D, 1, 4, 0, 4, 4);
        drive(1, 0, 0, 32'h0, 0, 0, 0, 0, 0);

        // All addresses read zero / not busy after reset.
        for (int a = 0; a < DEPTH; a++) begin
            idle(a, DEPTH - 1 - a);
            #3;
            check("rst_data1", bus.data1, 32'h0);
            check("rst_data2", bus.data2, 32'h0);
            check("rst_busy1", 32'(bus.busy1), 32'h0);
            check("rst_busy2", 32'(bus.busy2), 32'h0);
            check("rst_pending", 32'(bus.pending_count), 32'h0);
        end

        // x0 is hardwired.
        drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 1, 0, 0, 0, 0);
        idle(0, 0);
        #3;
        check("x0_data", bus.data1, 32'h0);
        check("x0_busy", 32'(bus.busy1), 32'h0);
        check("x0_pending", 32'(bus.pending_count), 32'h0);

        // Issue x5, x7, then write back x5.
        drive(0, 0, 0, 32'h0, 1, 5, 0, 5, 7);
        drive(0, 0, 0, 32'h0, 1, 7, 0, 5, 7);
        drive(0, 1, 5, 32'h12345678, 0, 0, 0, 5, 7);
        idle(5, 7);
        #3;
        check("wb_data_x5", bus.data1, 32'h12345678);
        check("wb_busy_x5", 32'(bus.busy1), 32'h0);
        check("wb_busy_x7", 32'(bus.busy2), 32'h1);
        check("wb_pending", 32'(bus.pending_count), 32'd1);

        // Same-cycle issue and writeback to x9: issue wins.
        drive(0, 1, 9, 32'hA5A5A5A5, 1, 9, 0, 9, 7);
        idle(9, 7);
        #3;
        check("iw_data_x9", bus.data1, 32'hA5A5A5A5);
        check("iw_busy_x9", 32'(bus.busy1), 32'h1);
        check("iw_pending", 32'(bus.pending_count), 32'd2);

        // Issue x1..x4, then flush with a blocked issue and a live write.
        for (int r = 1; r <= 4; r++) drive(0, 0, 0, 32'h0, 1, r, 0, r, 0);
        idle(0, 0);
        #3;
        check("pre_flush_pending", 32'(bus.pending_count), 32'd6);
        drive(0, 1, 2, 32'h55, 1, 6, 1, 6, 2);
        idle(2, 6);
        #3;
        check("fl_data_x2", bus.data1, 32'h55);
        check("fl_busy_x2", 32'(bus.busy1), 32'h0);
        check("fl_busy_x6", 32'(bus.busy2), 32'h0);
        check("fl_pending", 32'(bus.pending_count), 32'd0);
        for (int a = 0; a < DEPTH; a += 2) begin
            idle(a, a + 1);
            #3;
            check("fl_all_busy1", 32'(bus.busy1), 32'h0);
            check("fl_all_busy2", 32'(bus.busy2), 32'h0);
        end

        // Read-during-write of x3.
        drive(0, 1, 3, 32'h1111, 0, 0, 0, 0, 0);
        drive(0, 1, 3, 32'hDEAD, 0, 0, 0, 3, 0);
        #3;
`ifdef REGFILE_BYPASS_EN
        check("rdw_same_cycle", bus.data1, 32'hDEAD);
`else
        check("rdw_same_cycle", bus.data1, 32'h1111);
`endif
        idle(3, 0);
        #3;
        check("rdw_next_cycle", bus.data1, 32'hDEAD);

        // Reset mid-operation with pending marks and a concurrent write.
        drive(0, 0, 0, 32'h0, 1, 12, 0, 0, 0);
        drive(0, 1, 12, 32'h77, 1, 13, 0, 0, 0);
        drive(1, 1, 14, 32'h99, 1, 14, 0, 0, 0);
        idle(12, 14);
        #3;
        check("mid_rst_data12", bus.data1, 32'h0);
        check("mid_rst_data14", bus.data2, 32'h0);
        check("mid_rst_busy14", 32'(bus.busy2), 32'h0);
        check("mid_rst_pending", 32'(bus.pending_count), 32'h0);

        // Randomized traffic, checked by the compare process every cycle.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 2) != 0), int'($urandom_range(0, DEPTH - 1)), $urandom(),
                  ($urandom_range(0, 2) != 0), int'($urandom_range(0, DEPTH - 1)),
                  ($urandom_range(0, 24) == 0),
                  int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
        end
        idle(0, 0);
        @(negedge clk);
        #4;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
